regfile_wb_arbiter: RTL

- Write-side master for the 32x32 integer register file in the RV32 core.
- Collects completed results from the execution units: ALU, load/store unit and multiply/divide unit.
- Arbitrates them round-robin onto the register file's single write port and drives it from registered outputs.
- Keeps a pending-write scoreboard (busy mask) that issue logic uses for RAW/WAW stalls.

---
 rtl/regfile_wb_arbiter_pkg.sv | 18 +
 rtl/regfile_wb_arbiter_rr_arbiter.sv | 61 ++++++
 rtl/regfile_wb_arbiter.sv | 106 ++++++++++
 3 files changed

// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared core constants for the register-file write-back path.
// Latency: n/a (constants only).
// Backpressure: n/a.
package regfile_wb_arbiter_pkg;

    localparam int XLEN    = 32;  // integer data width
    localparam int AW      = 5;   // register address width (32 GPRs)
    localparam int NUM_SRC = 3;   // result sources feeding the write port

    // Result source indices on the write-back arbiter
    localparam int SRC_ALU = 0;
    localparam int SRC_LSU = 1;
    localparam int SRC_MDU = 2;

    // Hard-wired zero register; writes to it are discarded
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/regfile_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant, search starts just after the last grant.
// Latency: grant is combinational from req; pointer updates on the edge after advance.
// Backpressure: grants at most one requester per cycle; the pointer holds while advance is low.
//
// Ports:
//   clk, rst      clock, synchronous active-high reset (pointer -> N-1, so index 0 wins first)
//   req           request vector
//   advance       a granted transfer actually happened this cycle
//   gnt           one-hot grant, never set for a non-requesting index
//   gnt_idx       binary index of the granted requester (pointer value when none)
//   gnt_any       some requester is granted
module rr_arbiter #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);

    logic [IW-1:0] last_grant_q;
    logic [IW-1:0] last_grant_d;

    // Rotating priority: check last_grant+1, last_grant+2, ... wrapping, and
    // take the first requester seen. The last grantee is checked last.
    always_comb begin
        int j;
        j       = 0;
        gnt     = '0;
        gnt_idx = last_grant_q;
        gnt_any = 1'b0;
        for (int k = 1; k <= N; k++) begin
            j = (int'(last_grant_q) + k) % N;
            if (!gnt_any && req[j]) begin
                gnt[j]  = 1'b1;
                gnt_idx = IW'(j);
                gnt_any = 1'b1;
            end
        end
    end

    always_comb begin
        last_grant_d = last_grant_q;
        if (advance && gnt_any) begin
            last_grant_d = gnt_idx;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_grant_q <= IW'(N - 1);
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Register-file write master: round-robin merge of ALU/LSU/MDU results onto one write port, plus busy scoreboard.
// Latency: 1 cycle from transfer to wb_we/wb_addr/wb_data; busy_mask updates the cycle after issue/transfer.
// Backpressure: accepts exactly one result per cycle; ungranted sources hold valid/data until granted.
//
// Ports:
//   clk, rst                    clock, synchronous active-high reset
//   src_valid/src_rd/src_data   per-source result, slice i of the packed buses
//   src_ready                   one-hot grant (combinational from src_valid, low during reset)
//   issue_valid/issue_rd        issuing instruction with a destination; marks rd busy
//   wb_we/wb_addr/wb_data       registered register-file write port
//   busy_mask                   bit r set while a write to xr is outstanding
module regfile_wb_arbiter #(
    parameter int NUM_SRC = regfile_wb_arbiter_pkg::NUM_SRC,
    parameter int XLEN    = regfile_wb_arbiter_pkg::XLEN,
    parameter int AW      = regfile_wb_arbiter_pkg::AW
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_SRC-1:0]      src_valid,
    input  logic [NUM_SRC*AW-1:0]   src_rd,
    input  logic [NUM_SRC*XLEN-1:0] src_data,
    output logic [NUM_SRC-1:0]      src_ready,
    input  logic                    issue_valid,
    input  logic [AW-1:0]           issue_rd,
    output logic                    wb_we,
    output logic [AW-1:0]           wb_addr,
    output logic [XLEN-1:0]         wb_data,
    output logic [31:0]             busy_mask
);

    import regfile_wb_arbiter_pkg::*;

    localparam int IW = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] gnt;
    logic [IW-1:0]      gnt_idx;
    logic               gnt_any;
    logic               transfer;
    logic [AW-1:0]      sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic               wb_we_q,   wb_we_d;
    logic [AW-1:0]      wb_addr_q, wb_addr_d;
    logic [XLEN-1:0]    wb_data_q, wb_data_d;
    logic [31:0]        busy_q,    busy_d;

    rr_arbiter #(
        .N  (NUM_SRC),
        .IW (IW)
    ) u_rr_arbiter (
        .clk     (clk),
        .rst     (rst),
        .req     (src_valid),
        .advance (transfer),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    // Grants are suppressed during reset so no source believes its result
    // was taken while the write registers are being cleared.
    always_comb begin
        src_ready = rst ? '0 : gnt;
        transfer  = gnt_any && !rst;
        sel_rd    = src_rd[int'(gnt_idx)*AW +: AW];
        sel_data  = src_data[int'(gnt_idx)*XLEN +: XLEN];
    end

    always_comb begin
        // An rd=x0 result still consumes its grant but never raises wb_we.
        wb_we_d   = transfer && (sel_rd != AW'(REG_ZERO));
        wb_addr_d = transfer ? sel_rd   : wb_addr_q;
        wb_data_d = transfer ? sel_data : wb_data_q;

        // Clear first, then set: a same-cycle issue to the register being
        // written back is a newer producer and must keep it busy.
        busy_d = busy_q;
        if (wb_we_d) begin
            busy_d[sel_rd] = 1'b0;
        end
        if (issue_valid && (issue_rd != AW'(REG_ZERO))) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[REG_ZERO] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wb_we_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
            busy_q    <= '0;
        end else begin
            wb_we_q   <= wb_we_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wb_we     = wb_we_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;
    assign busy_mask = busy_q;

endmodule
